cm_lvl_fc: RTL and testbench

- Level-tracking flow controller for a CAPACITY-entry buffer.
- Counts accepted increments and decrements and drives a cm_if_lvl.mst interface: level, limit flag and threshold compare.
- Generates a hysteretic xoff back-pressure signal toward the upstream producer.
- Sits beside a FIFO, credit pool or buffer manager that owns the storage but not the occupancy accounting.

---
 rtl/cm_lvl_fc_pkg.sv | 21 ++
 rtl/cm_lvl_fc_if.sv | 15 +
 rtl/cm_lvl_fc_cnt.sv | 57 +++++
 rtl/cm_lvl_fc.sv | 104 ++++++++++
 tb/tb_cm_lvl_fc.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cm_lvl_fc_pkg.sv
// Shared types and helpers for the level-tracking flow controller.
package cm_lvl_fc_pkg;

    typedef enum logic {FC_XON, FC_XOFF} fc_state_t;

    // Bits needed to hold values 0..n-1.
    function automatic int sclog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // max(a-b, 0), truncated to w bits.
    function automatic int sat_sub(input int a, input int b, input int w);
        int d;
        d = (a > b) ? (a - b) : 0;
        return d & ((1 << w) - 1);
    endfunction

endpackage

// File: rtl/cm_lvl_fc_if.sv
// Level-report bundle: the controller drives level/flags, the consumer supplies the threshold.
interface cm_if_lvl #(parameter int CAPACITY = 16);
    import cm_lvl_fc_pkg::*;

    localparam int W = sclog2(CAPACITY + 1);

    logic         lim;
    logic [W-1:0] lvl;
    logic         lvl_gte;
    logic [W-1:0] lvl_thr;

    modport mst (output lim, lvl, lvl_gte, input lvl_thr);
    modport slv (input lim, lvl, lvl_gte, output lvl_thr);

endinterface

// File: rtl/cm_lvl_fc_cnt.sv
// Saturating up/down occupancy counter with sticky overflow/underflow detection.
module cm_lvl_cnt #(
    parameter int CAPACITY = 16,
    parameter int W        = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_err_clr,
    output logic [W-1:0] o_lvl,
    output logic [W-1:0] o_lvl_n,
    output logic         o_ovf,
    output logic         o_udf
);

    localparam logic [W-1:0] CAP_W = W'(CAPACITY);

    logic [W-1:0] r_lvl;
    logic         r_ovf;
    logic         r_udf;
    logic [W-1:0] w_lvl_n;
    logic         w_ovf_set;
    logic         w_udf_set;

    // Simultaneous inc and dec cancel, so they never raise an error even at the limits.
    always_comb begin
        w_lvl_n   = r_lvl;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_lvl == CAP_W) w_ovf_set = 1'b1;
            else                w_lvl_n   = r_lvl + W'(1);
        end else if (i_dec && !i_inc) begin
            if (r_lvl == '0) w_udf_set = 1'b1;
            else             w_lvl_n   = r_lvl - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_lvl <= w_lvl_n;
            r_ovf <= w_ovf_set | (r_ovf & ~i_err_clr);
            r_udf <= w_udf_set | (r_udf & ~i_err_clr);
        end
    end

    assign o_lvl   = r_lvl;
    assign o_lvl_n = w_lvl_n;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: rtl/cm_lvl_fc.sv
// Level-tracking flow controller: occupancy count, full/empty/limit flags,
// threshold compare and hysteretic xoff toward the upstream producer.
module cm_lvl_fc
    import cm_lvl_fc_pkg::*;
#(
    parameter int CAPACITY = 16,
    parameter bit LIM_FULL = 1'b1,
    parameter int HYST     = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  dec,
    cm_if_lvl.mst lvl_if,
    output logic  full,
    output logic  empty,
    output logic  xoff,
    output logic  ovf,
    output logic  udf,
    input  logic  err_clr
);

    localparam int           W     = sclog2(CAPACITY + 1);
    localparam logic [W-1:0] CAP_W = W'(CAPACITY);

    logic [W-1:0] w_lvl;
    logic [W-1:0] w_lvl_n;
    logic         w_thr_zero;
    logic         w_thr_over;
    logic         w_gte_n;
    logic [W:0]   w_rel;

    logic         r_full;
    logic         r_empty;
    logic         r_lim;
    logic         r_gte;
    logic         r_xoff;
    fc_state_t    r_state;

    cm_lvl_cnt #(
        .CAPACITY (CAPACITY),
        .W        (W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (inc),
        .i_dec     (dec),
        .i_err_clr (err_clr),
        .o_lvl     (w_lvl),
        .o_lvl_n   (w_lvl_n),
        .o_ovf     (ovf),
        .o_udf     (udf)
    );

    // Release point is one bit wider so thresholds below HYST saturate to 0 instead of wrapping.
    always_comb begin
        w_thr_zero = (lvl_if.lvl_thr == '0);
        w_thr_over = (lvl_if.lvl_thr > CAP_W);
        w_gte_n    = w_thr_zero ? 1'b1 : (w_thr_over ? 1'b0 : (w_lvl_n >= lvl_if.lvl_thr));
        w_rel      = (W + 1)'(sat_sub(int'(lvl_if.lvl_thr), HYST, W + 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_lim   <= !LIM_FULL;
            r_gte   <= w_thr_zero;
            r_xoff  <= 1'b0;
            r_state <= FC_XON;
        end else begin
            r_full  <= (w_lvl_n == CAP_W);
            r_empty <= (w_lvl_n == '0);
            r_lim   <= LIM_FULL ? (w_lvl_n == CAP_W) : (w_lvl_n == '0);
            r_gte   <= w_gte_n;
            case (r_state)
                FC_XON: begin
                    if (!w_thr_zero && (w_lvl_n >= lvl_if.lvl_thr)) begin
                        r_state <= FC_XOFF;
                        r_xoff  <= 1'b1;
                    end
                end
                FC_XOFF: begin
                    if (w_thr_zero || ({1'b0, w_lvl_n} < w_rel)) begin
                        r_state <= FC_XON;
                        r_xoff  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FC_XON;
                    r_xoff  <= 1'b0;
                end
            endcase
        end
    end

    assign lvl_if.lvl     = w_lvl;
    assign lvl_if.lim     = r_lim;
    assign lvl_if.lvl_gte = r_gte;
    assign full           = r_full;
    assign empty          = r_empty;
    assign xoff           = r_xoff;

endmodule

// File: tb/tb_cm_lvl_fc.sv
// Directed bench for cm_lvl_fc with CAPACITY=16, LIM_FULL=1, HYST=2.
module tb_cm_lvl_fc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic err_clr = 1'b0;
    logic full, empty, xoff, ovf, udf;
    int   checks = 0;
    int   errors = 0;

    cm_if_lvl #(.CAPACITY(16)) lvl_if ();

    cm_lvl_fc #(
        .CAPACITY (16),
        .LIM_FULL (1'b1),
        .HYST     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .lvl_if  (lvl_if),
        .full    (full),
        .empty   (empty),
        .xoff    (xoff),
        .ovf     (ovf),
        .udf     (udf),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input logic i, input logic d, input logic c);
        inc = i; dec = d; err_clr = c;
        @(posedge clk);
        #1;
        inc = 1'b0; dec = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        lvl_if.lvl_thr = 5'd12;

        // Reset with inc asserted: the inc must be ignored.
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_lvl", lvl_if.lvl, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_lim", lvl_if.lim, 0);
        check("rst_gte", lvl_if.lvl_gte, 0);
        check("rst_xoff", xoff, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);

        // Fill to capacity; threshold 12 trips gte and xoff.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check("fill_lvl", lvl_if.lvl, k);
            check("fill_gte", lvl_if.lvl_gte, (k >= 12) ? 1 : 0);
            check("fill_xoff", xoff, (k >= 12) ? 1 : 0);
            check("fill_full", full, (k == 16) ? 1 : 0);
            check("fill_lim", lvl_if.lim, (k == 16) ? 1 : 0);
            check("fill_empty", empty, 0);
            check("fill_ovf", ovf, 0);
        end

        // Overflow at full, then clear.
        step(1'b1, 1'b0, 1'b0);
        check("ovf_lvl", lvl_if.lvl, 16);
        check("ovf_set", ovf, 1);
        step(1'b0, 1'b0, 1'b1);
        check("ovf_clr", ovf, 0);
        check("ovf_full", full, 1);
        step(1'b1, 1'b1, 1'b0);
        check("both_full_lvl", lvl_if.lvl, 16);
        check("both_full_ovf", ovf, 0);

        // Drain to 12: still XOFF (release at 10).
        for (int k = 15; k >= 12; k--) begin
            step(1'b0, 1'b1, 1'b0);
            check("drain_lvl", lvl_if.lvl, k);
            check("drain_xoff", xoff, 1);
            check("drain_full", full, 0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("hy11_lvl", lvl_if.lvl, 11);
        check("hy11_xoff", xoff, 1);
        check("hy11_gte", lvl_if.lvl_gte, 0);
        step(1'b0, 1'b1, 1'b0);
        check("hy10_xoff", xoff, 1);
        step(1'b0, 1'b1, 1'b0);
        check("hy9_lvl", lvl_if.lvl, 9);
        check("hy9_xoff", xoff, 0);

        // Drain to empty.
        for (int k = 8; k >= 0; k--) step(1'b0, 1'b1, 1'b0);
        check("empty_lvl", lvl_if.lvl, 0);
        check("empty_flag", empty, 1);
        check("empty_udf", udf, 0);

        // inc&dec at empty: no change, no error.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            check("both_empty_lvl", lvl_if.lvl, 0);
            check("both_empty_flag", empty, 1);
            check("both_empty_udf", udf, 0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("udf_set", udf, 1);
        check("udf_lvl", lvl_if.lvl, 0);
        // New underflow together with err_clr: set wins.
        step(1'b0, 1'b1, 1'b1);
        check("udf_setwins", udf, 1);
        step(1'b0, 1'b0, 1'b1);
        check("udf_clr", udf, 0);

        // Zero threshold forces gte with no xoff.
        lvl_if.lvl_thr = 5'd0;
        step(1'b0, 1'b0, 1'b0);
        check("thr0_gte", lvl_if.lvl_gte, 1);
        check("thr0_xoff", xoff, 0);

        // Threshold above capacity: never gte, never xoff.
        lvl_if.lvl_thr = 5'd17;
        for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 1'b0);
        check("thr17_lvl", lvl_if.lvl, 16);
        check("thr17_gte", lvl_if.lvl_gte, 0);
        check("thr17_xoff", xoff, 0);
        check("thr17_lim", lvl_if.lim, 1);

        // Enter XOFF at threshold 9, then release by zeroing the threshold.
        step(1'b1, 1'b0, 1'b0);
        check("pre_ovf", ovf, 1);
        lvl_if.lvl_thr = 5'd9;
        step(1'b0, 1'b0, 1'b0);
        check("thr9_xoff", xoff, 1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0);
        check("thr9_lvl", lvl_if.lvl, 9);
        check("thr9_hold", xoff, 1);
        lvl_if.lvl_thr = 5'd0;
        step(1'b0, 1'b0, 1'b0);
        check("thr_to0_xoff", xoff, 0);
        lvl_if.lvl_thr = 5'd9;
        step(1'b0, 1'b0, 1'b0);
        check("rexoff", xoff, 1);

        // Reset mid-operation with inc in the same cycle.
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("mrst_lvl", lvl_if.lvl, 0);
        check("mrst_xoff", xoff, 0);
        check("mrst_empty", empty, 1);
        check("mrst_ovf", ovf, 0);
        check("mrst_udf", udf, 0);
        check("mrst_lim", lvl_if.lim, 0);
        step(1'b0, 1'b0, 1'b0);
        check("post_rst_lvl", lvl_if.lvl, 0);
        check("post_rst_xoff", xoff, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
